// File: rtl/tctb_pkg.sv
// Shared types and helpers for the tristate conduit timing bridge.
package tctb_pkg;
  localparam int CNT_W  = 4;
  localparam int MAX_CS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    TURN
  } tctb_state_e;

  // An index at or beyond num_cs gives an all-high vector, so the cycle still
  // runs but no device is selected.
  function automatic logic [MAX_CS-1:0] cs_decode(input logic [2:0] sel, input int num_cs);
    logic [MAX_CS-1:0] v;
    v = '1;
    if (int'(sel) < num_cs) v[sel] = 1'b0;
    return v;
  endfunction
endpackage

// File: rtl/tristate_conduit_wait_counter.sv
// Loadable down-counter that times every conduit phase; last flags the final cycle.
module tristate_conduit_wait_counter
  import tctb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);
endmodule

// File: rtl/tristate_conduit_timing_bridge.sv
// Avalon-MM slave to tristate conduit bridge with programmable setup/wait/hold/turnaround.
module tristate_conduit_timing_bridge
  import tctb_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int NUM_CS     = 1,
  parameter int SETUP_CYC  = 1,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1,
  localparam int CS_SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W+CS_SEL_W-1:0]   avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [DATA_W-1:0]            avs_writedata,
  output logic                         avs_waitrequest,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_readdatavalid,
  output logic [ADDR_W-1:0]            tcm_address_out,
  output logic                         tcm_read_n_out,
  output logic                         tcm_write_n_out,
  output logic [NUM_CS-1:0]            tcm_chipselect_n_out,
  output logic [DATA_W-1:0]            tcm_data_out,
  output logic                         tcm_data_outen,
  input  logic [DATA_W-1:0]            tcm_data_in
);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);

  tctb_state_e      state, nstate;
  logic             accept, load, last;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       avs_sel, lat_sel, cur_sel;
  logic             lat_rd, cur_rd, in_cyc, cs_ok;
  logic [MAX_CS-1:0] cs_full;
  logic             unused_cs;

  generate
    if (CS_SEL_W > 0) begin : g_sel
      assign avs_sel = 3'(avs_address[ADDR_W+CS_SEL_W-1:ADDR_W]);
    end else begin : g_nosel
      assign avs_sel = 3'd0;
    end
  endgenerate

  assign accept  = (state == IDLE) && !avs_waitrequest && (avs_read || avs_write);
  // Outputs are registered from the next state, so the accept cycle must use
  // the live request fields rather than the latched copies.
  assign cur_rd  = accept ? avs_read : lat_rd;
  assign cur_sel = accept ? avs_sel  : lat_sel;
  assign cs_full = cs_decode(cur_sel, NUM_CS);
  assign cs_ok   = int'(lat_sel) < NUM_CS;
  assign in_cyc  = (nstate == SETUP) || (nstate == ACCESS) || (nstate == HOLD);
  assign unused_cs = ^cs_full;

  tristate_conduit_wait_counter u_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .last     (last)
  );

  // Zero-length phases are skipped here so the FSM never spends a cycle in them.
  always_comb begin
    nstate   = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: if (accept) begin
        load = 1'b1;
        if (SETUP_CYC > 0) begin
          nstate   = SETUP;
          load_val = SETUP_LD;
        end else begin
          nstate   = ACCESS;
          load_val = avs_read ? RD_LD : WR_LD;
        end
      end
      SETUP: if (last) begin
        nstate   = ACCESS;
        load     = 1'b1;
        load_val = lat_rd ? RD_LD : WR_LD;
      end
      ACCESS: if (last) begin
        if (HOLD_CYC > 0) begin
          nstate   = HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
        end else if (lat_rd && TURN_CYC > 0) begin
          nstate   = TURN;
          load     = 1'b1;
          load_val = TURN_LD;
        end else begin
          nstate = IDLE;
        end
      end
      HOLD: if (last) begin
        if (lat_rd && TURN_CYC > 0) begin
          nstate   = TURN;
          load     = 1'b1;
          load_val = TURN_LD;
        end else begin
          nstate = IDLE;
        end
      end
      TURN: if (last) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      lat_rd               <= 1'b0;
      lat_sel              <= '0;
      avs_waitrequest      <= 1'b1;
      avs_readdatavalid    <= 1'b0;
      avs_readdata         <= '0;
      tcm_address_out      <= '0;
      tcm_read_n_out       <= 1'b1;
      tcm_write_n_out      <= 1'b1;
      tcm_chipselect_n_out <= '1;
      tcm_data_out         <= '0;
      tcm_data_outen       <= 1'b0;
    end else begin
      state             <= nstate;
      avs_waitrequest   <= (nstate != IDLE);
      avs_readdatavalid <= 1'b0;
      if (accept) begin
        lat_rd          <= avs_read;
        lat_sel         <= avs_sel;
        tcm_address_out <= avs_address[ADDR_W-1:0];
        if (!avs_read) tcm_data_out <= avs_writedata;
      end
      tcm_read_n_out       <= !((nstate == ACCESS) && cur_rd);
      tcm_write_n_out      <= !((nstate == ACCESS) && !cur_rd);
      tcm_chipselect_n_out <= in_cyc ? cs_full[NUM_CS-1:0] : '1;
      tcm_data_outen       <= in_cyc && !cur_rd;
      if ((state == ACCESS) && last && lat_rd) begin
        avs_readdatavalid <= 1'b1;
        avs_readdata      <= cs_ok ? tcm_data_in : '0;
      end
    end
  end
endmodule

// File: tb/tb_tristate_conduit_timing_bridge.sv
// Randomized bench: two bridge configurations checked cycle by cycle against a phase-length model.
module tb_tristate_conduit_timing_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance 0: defaults; instance 1: 3 chip selects, no setup/hold/turn
  logic        r0, w0, r1, w1;
  logic [21:0] ad0;
  logic [23:0] ad1;
  logic [15:0] wd0, wd1, din0, din1;
  logic        wt0, rdv0, rn0, wn0, oe0, wt1, rdv1, rn1, wn1, oe1;
  logic [15:0] rd0, rd1, do0, do1;
  logic [21:0] ta0, ta1;
  logic [0:0]  cs0;
  logic [2:0]  cs1;

  tristate_conduit_timing_bridge u_d0 (
    .clk(clk), .reset(rst), .avs_address(ad0), .avs_read(r0), .avs_write(w0),
    .avs_writedata(wd0), .avs_waitrequest(wt0), .avs_readdata(rd0), .avs_readdatavalid(rdv0),
    .tcm_address_out(ta0), .tcm_read_n_out(rn0), .tcm_write_n_out(wn0),
    .tcm_chipselect_n_out(cs0), .tcm_data_out(do0), .tcm_data_outen(oe0), .tcm_data_in(din0));

  tristate_conduit_timing_bridge #(
    .NUM_CS(3), .SETUP_CYC(0), .READ_WAIT(2), .WRITE_WAIT(3), .HOLD_CYC(0), .TURN_CYC(0)
  ) u_d1 (
    .clk(clk), .reset(rst), .avs_address(ad1), .avs_read(r1), .avs_write(w1),
    .avs_writedata(wd1), .avs_waitrequest(wt1), .avs_readdata(rd1), .avs_readdatavalid(rdv1),
    .tcm_address_out(ta1), .tcm_read_n_out(rn1), .tcm_write_n_out(wn1),
    .tcm_chipselect_n_out(cs1), .tcm_data_out(do1), .tcm_data_outen(oe1), .tcm_data_in(din1));

  int P_S[2]   = '{1, 0};
  int P_RW[2]  = '{2, 2};
  int P_WW[2]  = '{2, 3};
  int P_H[2]   = '{1, 0};
  int P_T[2]   = '{1, 0};
  int P_NCS[2] = '{1, 3};

  typedef struct packed {
    logic        wt, rdv;
    logic [15:0] rd;
    logic [21:0] ta;
    logic        rn, wn;
    logic [7:0]  cs;
    logic [15:0] dout;
    logic        oe;
  } obs_t;

  int total = 0, bad = 0, cur_txn = 0, cur_k = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s txn=%0d cyc=%0d got=%h exp=%h", tag, cur_txn, cur_k, got, exp);
    end
  endtask

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    if (inst == 0) o = '{wt0, rdv0, rd0, ta0, rn0, wn0, {7'h7f, cs0}, do0, oe0};
    else           o = '{wt1, rdv1, rd1, ta1, rn1, wn1, {5'h1f, cs1}, do1, oe1};
    return o;
  endfunction

  task automatic drive(input int inst, input logic rd, input logic wr, input logic [21:0] addr,
                       input logic [1:0] sel, input logic [15:0] wd);
    if (inst == 0) begin r0 = rd; w0 = wr; ad0 = addr; wd0 = wd; end
    else begin r1 = rd; w1 = wr; ad1 = {sel, addr}; wd1 = wd; end
  endtask

  task automatic set_din(input int inst, input logic [15:0] v);
    if (inst == 0) din0 = v; else din1 = v;
  endtask

  // Called at a falling edge; the expected trace comes from phase lengths alone.
  task automatic txn(input int inst, input logic rd, input logic wr, input logic [21:0] addr,
                     input logic [1:0] sel, input logic [15:0] wd, input logic [15:0] rdval);
    int s, a, h, t, n, budget;
    logic is_rd, busy, incyc, acc, sel_ok;
    logic [7:0] ecs;
    obs_t o;
    cur_txn++;
    cur_k  = 0;
    budget = 50;
    o = get_obs(inst);
    while (o.wt !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
      o = get_obs(inst);
    end
    if (budget == 0) chk("accept_timeout", 1, 0);
    is_rd  = rd;
    s      = P_S[inst];
    a      = is_rd ? P_RW[inst] : P_WW[inst];
    h      = P_H[inst];
    t      = is_rd ? P_T[inst] : 0;
    n      = s + a + h + t;
    sel_ok = int'(sel) < P_NCS[inst];
    ecs    = 8'hff;
    if (sel_ok) ecs[sel] = 1'b0;
    set_din(inst, ~rdval);
    drive(inst, rd, wr, addr, sel, wd);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      cur_k = k;
      if (k == 1) drive(inst, 1'b0, 1'b0, 22'($urandom), 2'($urandom), 16'($urandom));
      set_din(inst, (is_rd && k == s + a) ? rdval : ~rdval);
      o     = get_obs(inst);
      busy  = (k <= n);
      incyc = (k <= s + a + h);
      acc   = (k > s) && (k <= s + a);
      chk("waitrequest", o.wt, busy);
      chk("read_n", o.rn, !(acc && is_rd));
      chk("write_n", o.wn, !(acc && !is_rd));
      chk("cs_n", o.cs, incyc ? ecs : 8'hff);
      chk("outen", o.oe, incyc && !is_rd);
      chk("readdatavalid", o.rdv, is_rd && (k == s + a + 1));
      if (incyc) chk("address", o.ta, addr);
      if (incyc && !is_rd) chk("data_out", o.dout, wd);
      if (is_rd && k == s + a + 1) chk("readdata", o.rd, sel_ok ? rdval : 16'h0);
    end
  endtask

  task automatic check_reset_vals(input int inst);
    obs_t o;
    o = get_obs(inst);
    chk("rst_wait", o.wt, 1);
    chk("rst_rdv", o.rdv, 0);
    chk("rst_rdata", o.rd, 0);
    chk("rst_addr", o.ta, 0);
    chk("rst_read_n", o.rn, 1);
    chk("rst_write_n", o.wn, 1);
    chk("rst_cs_n", o.cs, 8'hff);
    chk("rst_dout", o.dout, 0);
    chk("rst_outen", o.oe, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    logic [1:0] sel;
    int inst, op;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    din0 = '0;
    din1 = '0;
    repeat (2) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;
    @(negedge clk);
    chk("wait_after_rst0", wt0, 0);
    chk("wait_after_rst1", wt1, 0);

    txn(0, 1, 0, 22'h001234, 0, 16'h0000, 16'hBEEF);
    txn(0, 0, 1, 22'h3FFFFF, 0, 16'hA5A5, 16'h0000);
    txn(1, 1, 0, 22'h0ABCDE, 2, 16'h0000, 16'h1357);
    txn(0, 1, 0, 22'h000010, 0, 16'h0000, 16'h2468);
    txn(0, 0, 1, 22'h000020, 0, 16'h5A5A, 16'h0000);
    txn(0, 1, 1, 22'h155555, 0, 16'hFFFF, 16'hC0DE);
    txn(1, 1, 1, 22'h2AAAAA, 1, 16'hFFFF, 16'h7777);
    txn(1, 1, 0, 22'h000333, 3, 16'h0000, 16'hDEAD);
    txn(1, 0, 1, 22'h000444, 3, 16'h9999, 16'h0000);
    txn(1, 0, 1, 22'h000555, 0, 16'h1111, 16'h0000);

    // abort a default read in its first ACCESS cycle
    cur_txn++;
    cur_k = 0;
    drive(0, 1, 0, 22'h000777, 0, 16'h0);
    @(negedge clk);
    drive(0, 0, 0, 22'h0, 0, 16'h0);
    @(negedge clk);
    cur_k = 2;
    chk("abort_pre_read_n", rn0, 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_read_n", rn0, 1);
    chk("abort_cs_n", cs0, 1);
    chk("abort_outen", oe0, 0);
    chk("abort_wait", wt0, 1);
    chk("abort_rdv", rdv0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_wait_held", wt0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("abort_wait_release", wt0, 0);
      chk("abort_no_rdv", rdv0, 0);
    end

    for (int i = 0; i < 40; i++) begin
      inst = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      sel  = (inst == 1) ? 2'($urandom_range(0, 3)) : 2'd0;
      txn(inst, op != 1, op != 0, 22'($urandom), sel, 16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
